// File: rtl/iommu_msi_filenum_ext_if.sv
// Request/response bundle for the MSI file-number extractor.
// Signal suffixes are from the extractor's point of view.
interface iommu_msi_filenum_ext_if #(
    parameter int ADDR_W = 52,
    parameter int PPN_W  = 44
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [ADDR_W-1:0]   gppn_i;
    logic [ADDR_W-1:0]   mask_i;
    logic [ADDR_W-1:0]   pattern_i;
    logic [3:0]          msiptp_mode_i;
    logic [PPN_W-1:0]    msiptp_ppn_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic                rsp_is_msi_o;
    logic [ADDR_W-1:0]   rsp_file_num_o;
    logic [PPN_W+11:0]   rsp_pte_addr_o;
    logic                rsp_fault_o;
    logic [11:0]         rsp_cause_o;

    modport master (
        output req_valid_i, gppn_i, mask_i, pattern_i,
        output msiptp_mode_i, msiptp_ppn_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_is_msi_o,
        input  rsp_file_num_o, rsp_pte_addr_o, rsp_fault_o, rsp_cause_o
    );

    modport slave (
        input  req_valid_i, gppn_i, mask_i, pattern_i,
        input  msiptp_mode_i, msiptp_ppn_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_is_msi_o,
        output rsp_file_num_o, rsp_pte_addr_o, rsp_fault_o, rsp_cause_o
    );
endinterface

// File: rtl/iommu_msi_filenum_ext.sv
// Iterative MSI address check and interrupt-file-number compressor.
// Optional IOMMU_MSI_FLUSH_EN adds flush_i to abort an in-flight request.
module iommu_msi_filenum_ext #(
    parameter int ADDR_W       = 52,
    parameter int BITS_PER_CYC = 13,
    parameter int PPN_W        = 44
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef IOMMU_MSI_FLUSH_EN
    input  logic flush_i,
`endif
    iommu_msi_filenum_ext_if.slave bus
);
    localparam int NCHUNK = (ADDR_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IDX_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int J_W    = $clog2(ADDR_W + 1);
    localparam int PTE_W  = PPN_W + 12;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXTRACT = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] gppn_q, gppn_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic [PPN_W-1:0]  ppn_q, ppn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [ADDR_W-1:0] fn_q, fn_d;
    logic [PTE_W-1:0]  pte_q, pte_d;
    logic              msi_q, msi_d;
    logic              fault_q, fault_d;
    logic [11:0]       cause_q, cause_d;

    logic [ADDR_W-1:0] fn_ext;
    logic [J_W-1:0]    j_ext;
    logic              accept;
    logic              hit;
    logic              flush;

`ifdef IOMMU_MSI_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign accept = bus.req_valid_i && (state_q == IDLE) && !flush;
    assign hit = ((bus.gppn_i ^ bus.pattern_i) & ~bus.mask_i) == '0;

    // One chunk of the mask per cycle; positions past ADDR_W are skipped.
    always_comb begin
        int jv;
        fn_ext = fn_q;
        jv = int'(j_q);
        for (int b = 0; b < BITS_PER_CYC; b++) begin
            int idx;
            idx = int'(cnt_q) * BITS_PER_CYC + b;
            if (idx < ADDR_W) begin
                if (mask_q[IDX_W'(idx)]) begin
                    fn_ext[IDX_W'(jv)] = gppn_q[IDX_W'(idx)];
                    jv = jv + 1;
                end
            end
        end
        j_ext = J_W'(jv);
    end

    always_comb begin
        state_d = state_q;
        gppn_d  = gppn_q;
        mask_d  = mask_q;
        ppn_d   = ppn_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        fn_d    = fn_q;
        pte_d   = pte_q;
        msi_d   = msi_q;
        fault_d = fault_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    gppn_d  = bus.gppn_i;
                    mask_d  = bus.mask_i;
                    ppn_d   = bus.msiptp_ppn_i;
                    cnt_d   = '0;
                    j_d     = '0;
                    fn_d    = '0;
                    pte_d   = '0;
                    msi_d   = 1'b0;
                    fault_d = 1'b0;
                    cause_d = '0;
                    state_d = RESP;
                    if (bus.msiptp_mode_i == 4'd1) begin
                        if (hit) begin
                            msi_d   = 1'b1;
                            state_d = EXTRACT;
                        end
                    end else if (bus.msiptp_mode_i != 4'd0) begin
                        fault_d = 1'b1;
                        cause_d = 12'd259;
                    end
                end
            end
            EXTRACT: begin
                fn_d  = fn_ext;
                j_d   = j_ext;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    state_d = RESP;
                    pte_d   = {ppn_q, 12'h000} + PTE_W'({fn_ext, 4'h0});
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gppn_q  <= '0;
            mask_q  <= '0;
            ppn_q   <= '0;
            cnt_q   <= '0;
            j_q     <= '0;
            fn_q    <= '0;
            pte_q   <= '0;
            msi_q   <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            gppn_q  <= gppn_d;
            mask_q  <= mask_d;
            ppn_q   <= ppn_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            fn_q    <= fn_d;
            pte_q   <= pte_d;
            msi_q   <= msi_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign bus.req_ready_o    = (state_q == IDLE);
    assign bus.rsp_valid_o    = (state_q == RESP);
    assign bus.rsp_is_msi_o   = msi_q;
    assign bus.rsp_file_num_o = fn_q;
    assign bus.rsp_pte_addr_o = pte_q;
    assign bus.rsp_fault_o    = fault_q;
    assign bus.rsp_cause_o    = cause_q;
endmodule
